modport_mem: RTL and testbench

MODPORT_MEM -- requirements
Module: modport_mem

---
 rtl/mem_pkg.sv | 11 +
 rtl/modport_mem_if.sv | 31 +++
 rtl/modport_mem.sv | 48 ++++
 tb/tb_modport_mem.sv | 134 +++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared defaults and word types for the modport_mem register-file memory.
package mem_pkg;

  localparam int ADDR_W_DEFAULT = 5;
  localparam int DATA_W_DEFAULT = 8;
  localparam int DEPTH_DEFAULT  = 2 ** ADDR_W_DEFAULT;

  typedef logic [ADDR_W_DEFAULT-1:0] addr_t;
  typedef logic [DATA_W_DEFAULT-1:0] data_t;

endpackage : mem_pkg

// File: rtl/modport_mem_if.sv
// Access bus of modport_mem: strobes, address and data grouped with master/slave views.
interface modport_mem_if
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) ();

  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;

  modport master (
    output read,
    output write,
    output addr,
    output data_in,
    input  data_out
  );

  modport slave (
    input  read,
    input  write,
    input  addr,
    input  data_in,
    output data_out
  );

endinterface : modport_mem_if

// File: rtl/modport_mem.sv
// Single-port flop-array memory with registered read data; write wins over read,
// and a synchronous reset clears every word as well as the read register.
module modport_mem
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic          clk,
  input  logic          rst,
  modport_mem_if.slave  bus
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;
  logic [ADDR_W-1:0] addr;

  assign addr         = bus.addr;
  assign bus.data_out = data_q;

  // Read data only moves on a pure read; a coincident write leaves it holding.
  always_comb begin
    data_d = data_q;
    if (bus.read && !bus.write) begin
      data_d = mem_q[addr];
    end
  end

  // NOTE: every state element here uses <= so all flops see pre-edge values of each other.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the array is reset word by word because reads after reset must return 0,
      // which rules out mapping this storage onto a non-resettable RAM macro.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      data_q <= '0;
    end else begin
      if (bus.write) begin
        mem_q[addr] <= bus.data_in;
      end
      data_q <= data_d;
    end
  end

endmodule : modport_mem

// File: tb/tb_modport_mem.sv
// Directed bench for modport_mem: a vector table of single-edge accesses plus
// hand-written reset, random-data and hold sequences.
module tb_modport_mem;
  import mem_pkg::*;

  typedef struct {
    logic  rd;
    logic  wr;
    addr_t addr;
    data_t din;
    data_t exp;
    string name;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;
  vec_t vecs[$];
  data_t sb [DEPTH_DEFAULT];

  modport_mem_if bus ();

  modport_mem dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input data_t act, input data_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: data_out=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive one access, let one rising edge pass, return 1 time unit later.
  task automatic cycle(input logic r, input logic w, input addr_t a, input data_t d);
    bus.read    = r;
    bus.write   = w;
    bus.addr    = a;
    bus.data_in = d;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic w, input addr_t a,
                              input data_t d, input data_t e, input string n);
    vec_t v;
    v.rd = r; v.wr = w; v.addr = a; v.din = d; v.exp = e; v.name = n;
    return v;
  endfunction

  initial begin
    addr_t xa;
    data_t xd;
    xa = 'x;
    xd = 'x;
    bus.read = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.data_in = '0;

    // Pre-load a non-zero pattern so the reset check proves the array is cleared.
    @(negedge clk);
    for (int k = 0; k < DEPTH_DEFAULT; k++) cycle(1'b0, 1'b1, addr_t'(k), ~data_t'(k));
    cycle(1'b1, 1'b0, addr_t'(7), '0);
    check("preload_read", bus.data_out, 8'hF8);

    rst = 1'b1;
    cycle(1'b1, 1'b1, addr_t'(2), 8'h77);
    cycle(1'b0, 1'b0, '0, '0);
    rst = 1'b0;
    check("reset_state", bus.data_out, 8'h00);

    for (int k = 0; k < DEPTH_DEFAULT; k++)
      vecs.push_back(mk(1'b1, 1'b0, addr_t'(k), 8'h00, 8'h00, "reset_read"));
    for (int k = 0; k < DEPTH_DEFAULT; k++)
      vecs.push_back(mk(1'b0, 1'b1, addr_t'(k), data_t'(k), 8'h00, "write_holds_out"));
    for (int k = 0; k < DEPTH_DEFAULT; k++)
      vecs.push_back(mk(1'b1, 1'b0, addr_t'(k), 8'h00, data_t'(k), "read_eq_addr"));
    vecs.push_back(mk(1'b0, 1'b1, 5'd3, 8'hA5, 8'd31, "write_a5"));
    vecs.push_back(mk(1'b1, 1'b0, 5'd3, 8'h00, 8'hA5, "read_a5"));
    vecs.push_back(mk(1'b1, 1'b1, 5'd3, 8'h5A, 8'hA5, "both_strobes_hold"));
    vecs.push_back(mk(1'b1, 1'b0, 5'd3, 8'h00, 8'h5A, "both_strobes_wrote"));
    vecs.push_back(mk(1'b0, 1'b0, xa,   xd,    8'h5A, "idle_x_inputs"));
    vecs.push_back(mk(1'b1, 1'b0, 5'd4, 8'h00, 8'h04, "x_idle_no_write"));
    vecs.push_back(mk(1'b1, 1'b0, 5'd3, 8'h00, 8'h5A, "reread_5a"));

    foreach (vecs[i]) begin
      cycle(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].din);
      check($sformatf("%s[%0d]", vecs[i].name, i), bus.data_out, vecs[i].exp);
    end

    // Random data across all addresses against a scoreboard.
    for (int k = 0; k < DEPTH_DEFAULT; k++) begin
      sb[k] = data_t'($urandom_range(0, 255));
      cycle(1'b0, 1'b1, addr_t'(k), sb[k]);
    end
    for (int k = 0; k < DEPTH_DEFAULT; k++) begin
      cycle(1'b1, 1'b0, addr_t'(k), '0);
      check($sformatf("rand_read[%0d]", k), bus.data_out, sb[k]);
    end

    // Reset in the middle of traffic, then normal access right after.
    cycle(1'b0, 1'b1, 5'd31, 8'hFF);
    cycle(1'b1, 1'b0, 5'd31, '0);
    check("read_ff", bus.data_out, 8'hFF);
    rst = 1'b1;
    cycle(1'b0, 1'b1, 5'd31, 8'h99);
    rst = 1'b0;
    check("mid_reset_out", bus.data_out, 8'h00);
    cycle(1'b1, 1'b0, 5'd31, '0);
    check("mid_reset_read31", bus.data_out, 8'h00);
    cycle(1'b1, 1'b0, 5'd5, '0);
    check("mid_reset_read5", bus.data_out, 8'h00);
    cycle(1'b0, 1'b1, 5'd7, 8'h12);
    cycle(1'b1, 1'b0, 5'd7, '0);
    check("post_reset_rw", bus.data_out, 8'h12);

    // Hold: read 3C then idle five edges with junk on the bus.
    cycle(1'b0, 1'b1, 5'd9, 8'h3C);
    cycle(1'b1, 1'b0, 5'd9, '0);
    check("read_3c", bus.data_out, 8'h3C);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 1'b0, addr_t'(k + 20), 8'hC3);
      check($sformatf("hold_3c[%0d]", k), bus.data_out, 8'h3C);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_modport_mem
